pin_entry_ctrl: RTL and testbench

PIN_ENTRY_CTRL -- requirements
Module: pin_entry_ctrl

---
 rtl/pin_entry_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: two-digit PIN entry, lock request/response handshake, post-unlock PIN reprogramming.
// Optional inter-digit timeout is compiled in when PIN_ENTRY_TIMEOUT_EN is defined.
module pin_entry_ctrl #(
  parameter logic [7:0] DEFAULT_PIN    = 8'hA5,
  parameter int         RESP_WAIT      = 8,
  parameter int         AUTH_CYCLES    = 64,
  parameter int         LOCKOUT_CYCLES = 16,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_clear,
  input  logic       prog_req,
  input  logic       lock_open,
  input  logic       deny_access,
  input  logic       alarm,
  output logic       req_access,
  output logic [7:0] pin,
  output logic       first_four_match,
  output logic       last_four_match,
  output logic       busy,
  output logic       pin_updated,
  output logic       entry_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DIGIT1    = 3'd1;
  localparam logic [2:0] S_REQUEST   = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_AUTH      = 3'd4;
  localparam logic [2:0] S_PROG_D0   = 3'd5;
  localparam logic [2:0] S_PROG_D1   = 3'd6;
  localparam logic [2:0] S_LOCKOUT   = 3'd7;

  // One shared dwell counter, sized for the longest of the timed states.
  localparam int MAX_A   = (RESP_WAIT > AUTH_CYCLES) ? RESP_WAIT : AUTH_CYCLES;
  localparam int MAX_B   = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_WAIT - 1);
  localparam logic [CNT_W-1:0] AUTH_LAST = CNT_W'(AUTH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  logic [2:0]       state;
  logic [2:0]       nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       stored;
  logic [3:0]       shadow;
  logic             to_expired;
  logic             timeout_hit;

`ifdef PIN_ENTRY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign to_expired = (cnt == TO_LAST);
`else
  assign to_expired = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    nxt_state   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: if (key_valid) nxt_state = S_DIGIT1;
      S_DIGIT1: begin
        if (key_clear)       nxt_state = S_IDLE;
        else if (key_valid)  nxt_state = S_REQUEST;
        else if (to_expired) begin
          nxt_state   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_REQUEST: nxt_state = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (alarm)                 nxt_state = S_LOCKOUT;
        else if (lock_open)        nxt_state = S_AUTH;
        else if (deny_access)      nxt_state = S_IDLE;
        else if (cnt == RESP_LAST) nxt_state = S_IDLE;
      end
      S_AUTH: begin
        if (prog_req)              nxt_state = S_PROG_D0;
        else if (key_valid)        nxt_state = S_IDLE;
        else if (cnt == AUTH_LAST) nxt_state = S_IDLE;
      end
      S_PROG_D0: begin
        if (key_clear)      nxt_state = S_IDLE;
        else if (key_valid) nxt_state = S_PROG_D1;
      end
      S_PROG_D1: begin
        if (key_clear)       nxt_state = S_IDLE;
        else if (key_valid)  nxt_state = S_IDLE;
        else if (to_expired) begin
          nxt_state   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_LOCKOUT: if (cnt == LOCK_LAST) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      stored           <= DEFAULT_PIN;
      shadow           <= '0;
      pin              <= '0;
      req_access       <= 1'b0;
      first_four_match <= 1'b0;
      last_four_match  <= 1'b0;
      pin_updated      <= 1'b0;
      entry_timeout    <= 1'b0;
    end else begin
      state <= nxt_state;
      // Dwell count restarts on every state change and saturates otherwise.
      if (nxt_state != state)  cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);

      req_access    <= (state == S_REQUEST);
      pin_updated   <= 1'b0;
      entry_timeout <= timeout_hit;

      case (state)
        S_IDLE: if (key_valid) pin[7:4] <= key_code;
        S_DIGIT1: if (!key_clear && key_valid) pin[3:0] <= key_code;
        S_REQUEST: begin
          first_four_match <= (pin[7:4] == stored[7:4]);
          last_four_match  <= (pin[3:0] == stored[3:0]);
        end
        S_WAIT_RESP: begin
          if (nxt_state != S_WAIT_RESP) begin
            first_four_match <= 1'b0;
            last_four_match  <= 1'b0;
          end
        end
        S_PROG_D0: begin
          if (key_clear)      shadow <= '0;
          else if (key_valid) shadow <= key_code;
        end
        S_PROG_D1: begin
          if (key_clear || timeout_hit) begin
            shadow <= '0;
          end else if (key_valid) begin
            stored      <= {shadow, key_code};
            shadow      <= '0;
            pin_updated <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed vector table, corner-case sequences and a random run against a reference model.
`timescale 1ns/1ps
module tb_pin_entry_ctrl;

  localparam int TO_CYC    = 100;
  localparam int RESP_CYC  = 8;
  localparam int AUTH_CYC  = 64;
  localparam int LOCK_CYC  = 16;
`ifdef PIN_ENTRY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, key_valid, key_clear, prog_req, lock_open, deny_access, alarm;
  logic [3:0] key_code;
  logic       req_access, first_four_match, last_four_match, busy, pin_updated, entry_timeout;
  logic [7:0] pin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  pin_entry_ctrl #(
    .DEFAULT_PIN(8'hA5), .RESP_WAIT(RESP_CYC), .AUTH_CYCLES(AUTH_CYC),
    .LOCKOUT_CYCLES(LOCK_CYC), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_clear(key_clear),
    .prog_req(prog_req), .lock_open(lock_open), .deny_access(deny_access), .alarm(alarm),
    .req_access(req_access), .pin(pin), .first_four_match(first_four_match),
    .last_four_match(last_four_match), .busy(busy), .pin_updated(pin_updated),
    .entry_timeout(entry_timeout)
  );

  // Reference model: phase, remaining cycles in the phase, queue of programmed digits.
  localparam int PH_IDLE = 0, PH_DIG = 1, PH_REQ = 2, PH_WAIT = 3,
                 PH_AUTH = 4, PH_P0 = 5, PH_P1 = 6, PH_LOCK = 7;
  int         m_ph, m_left;
  logic [3:0] m_q[$];
  logic [7:0] m_pin, m_stored;
  logic       m_req, m_f, m_l, m_upd, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_left = 0; m_q.delete();
    m_pin = 8'h00; m_stored = 8'hA5;
    m_req = 0; m_f = 0; m_l = 0; m_upd = 0; m_to = 0;
  endtask

  task automatic enter(input int ph, input int len);
    m_ph = ph; m_left = len;
  endtask

  // Count one cycle off the current phase; true when the phase's time is used up.
  function automatic bit spend();
    m_left = m_left - 1;
    return (m_left == 0);
  endfunction

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic kcl, input logic pr,
                            input logic lo, input logic da, input logic al);
    m_req = 0; m_upd = 0; m_to = 0;
    case (m_ph)
      PH_IDLE: if (kv) begin m_pin[7:4] = kc; enter(PH_DIG, TO_CYC); end
      PH_DIG: begin
        if (kcl) enter(PH_IDLE, 0);
        else if (kv) begin m_pin[3:0] = kc; enter(PH_REQ, 0); end
        else if (TO_EN && spend()) begin enter(PH_IDLE, 0); m_to = 1; end
      end
      PH_REQ: begin
        m_req = 1;
        m_f = (m_pin[7:4] == m_stored[7:4]);
        m_l = (m_pin[3:0] == m_stored[3:0]);
        enter(PH_WAIT, RESP_CYC);
      end
      PH_WAIT: begin
        if (al) enter(PH_LOCK, LOCK_CYC);
        else if (lo) enter(PH_AUTH, AUTH_CYC);
        else if (da) enter(PH_IDLE, 0);
        else if (spend()) enter(PH_IDLE, 0);
        if (m_ph != PH_WAIT) begin m_f = 0; m_l = 0; end
      end
      PH_AUTH: begin
        if (pr) begin m_q.delete(); enter(PH_P0, 0); end
        else if (kv) enter(PH_IDLE, 0);
        else if (spend()) enter(PH_IDLE, 0);
      end
      PH_P0: begin
        if (kcl) begin m_q.delete(); enter(PH_IDLE, 0); end
        else if (kv) begin m_q.push_back(kc); enter(PH_P1, TO_CYC); end
      end
      PH_P1: begin
        if (kcl) begin m_q.delete(); enter(PH_IDLE, 0); end
        else if (kv) begin
          m_stored = {m_q[0], kc}; m_q.delete(); m_upd = 1; enter(PH_IDLE, 0);
        end else if (TO_EN && spend()) begin m_q.delete(); enter(PH_IDLE, 0); m_to = 1; end
      end
      PH_LOCK: if (spend()) enter(PH_IDLE, 0);
      default: enter(PH_IDLE, 0);
    endcase
  endtask

  task automatic check_model();
    check("model busy", busy, (m_ph != PH_IDLE));
    check("model req_access", req_access, m_req);
    check("model pin", pin, m_pin);
    check("model first_four_match", first_four_match, m_f);
    check("model last_four_match", last_four_match, m_l);
    check("model pin_updated", pin_updated, m_upd);
    check("model entry_timeout", entry_timeout, m_to);
  endtask

  task automatic tick(input logic kv, input logic [3:0] kc, input logic kcl, input logic pr,
                      input logic lo, input logic da, input logic al);
    @(negedge clk);
    key_valid = kv; key_code = kc; key_clear = kcl; prog_req = pr;
    lock_open = lo; deny_access = da; alarm = al;
    @(posedge clk);
    cyc++;
    model_step(kv, kc, kcl, pr, lo, da, al);
    #1;
    check_model();
  endtask

  task automatic idle_tick();
    tick(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] k);
    tick(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_valid = 0; key_code = 0; key_clear = 0; prog_req = 0;
    lock_open = 0; deny_access = 0; alarm = 0;
    #1;
    check("reset busy", busy, 0);
    check("reset pin", pin, 8'h00);
    check("reset req_access", req_access, 0);
    check("reset first_four_match", first_four_match, 0);
    check("reset last_four_match", last_four_match, 0);
    check("reset pin_updated", pin_updated, 0);
    check("reset entry_timeout", entry_timeout, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic       kv;
    logic [3:0] kc;
    logic       kcl, pr, lo, da;
    logic       e_busy, e_req;
    logic [7:0] e_pin;
    logic       e_f, e_l, e_upd;
  } vec_t;

  vec_t vt[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] pool[4];
    logic       kv, kcl;
    logic [3:0] kc;

    // kv kc kcl pr lo da | busy req pin f l upd
    vt[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    vt[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    key_valid = 0; key_code = 0; key_clear = 0; prog_req = 0;
    lock_open = 0; deny_access = 0; alarm = 0;
    model_reset();
    do_reset();

    // Correct PIN, unlock, reprogram to 3C, old PIN rejected, new PIN accepted.
    for (int i = 0; i < 17; i++) begin
      tick(vt[i].kv, vt[i].kc, vt[i].kcl, vt[i].pr, vt[i].lo, vt[i].da, 1'b0);
      check($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d req_access", i), req_access, vt[i].e_req);
      check($sformatf("vec%0d pin", i), pin, vt[i].e_pin);
      check($sformatf("vec%0d first_four_match", i), first_four_match, vt[i].e_f);
      check($sformatf("vec%0d last_four_match", i), last_four_match, vt[i].e_l);
      check($sformatf("vec%0d pin_updated", i), pin_updated, vt[i].e_upd);
    end

    // Mid-entry reset discards the partial digit and restores the default PIN.
    key(4'h7);
    do_reset();

    // Wrong second digit, denied; then the same entry left unanswered.
    key(4'hA); key(4'h3); idle_tick();
    check("wrong req_access", req_access, 1);
    check("wrong first_four_match", first_four_match, 1);
    check("wrong last_four_match", last_four_match, 0);
    tick(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("deny busy", busy, 0);
    key(4'hA); key(4'h3); idle_tick();
    for (int i = 1; i <= RESP_CYC; i++) begin
      idle_tick();
      check($sformatf("resp wait %0d busy", i), busy, (i < RESP_CYC));
    end

    // key_clear beats a simultaneous key in DIGIT1.
    key(4'hA);
    tick(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clear wins busy", busy, 0);
    check("clear wins pin", pin, 8'hA3);

    // Alarm lockout: keys ignored for the lockout window, then accepted.
    key(4'hA); key(4'h5); idle_tick();
    tick(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("alarm busy", busy, 1);
    for (int i = 1; i <= LOCK_CYC; i++) begin
      tick(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("lockout %0d busy", i), busy, (i < LOCK_CYC));
    end
    key(4'h7);
    check("post lockout busy", busy, 1);
    check("post lockout pin", pin, 8'h75);

    // Inter-digit timeout behaviour depends on the build.
    do_reset();
    key(4'hA);
    for (int i = 1; i <= TO_CYC; i++) idle_tick();
    check("timeout entry_timeout", entry_timeout, TO_EN);
    check("timeout busy", busy, !TO_EN);

    // Random traffic against the reference model.
    do_reset();
    pool[0] = 4'hA; pool[1] = 4'h5; pool[2] = 4'h3; pool[3] = 4'hC;
    for (int i = 0; i < 3000; i++) begin
      kv  = ($urandom_range(0, 99) < 25);
      kcl = !kv && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) kc = pool[$urandom_range(0, 3)];
      else kc = 4'($urandom_range(0, 15));
      tick(kv, kc, kcl, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
